// File: rtl/comb_eval_arbiter_if.sv
// Bundle between the round-robin arbiter, its requesters, the shared
// (a ^ b) | c datapath and the response consumer.
//   req/a_in/b_in/c_in : per-requester request and operands (into arbiter)
//   gnt                : one-hot single-cycle grant pulse (out of arbiter)
//   dp_a/dp_b/dp_c     : registered operands to the shared datapath
//   dp_x               : combinational datapath result (into arbiter)
//   rsp_valid/rsp_id/rsp_x, rsp_ready : response handshake
//   busy               : arbiter not idle
interface comb_eval_arbiter_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
);
    logic [N-1:0]    req;
    logic [N-1:0]    a_in;
    logic [N-1:0]    b_in;
    logic [N-1:0]    c_in;
    logic [N-1:0]    gnt;
    logic            dp_a;
    logic            dp_b;
    logic            dp_c;
    logic            dp_x;
    logic            rsp_valid;
    logic [ID_W-1:0] rsp_id;
    logic            rsp_x;
    logic            rsp_ready;
    logic            busy;

    // Arbiter side
    modport slave (
        input  req, a_in, b_in, c_in, dp_x, rsp_ready,
        output gnt, dp_a, dp_b, dp_c, rsp_valid, rsp_id, rsp_x, busy
    );

    // Requester / datapath / consumer side
    modport master (
        output req, a_in, b_in, c_in, dp_x, rsp_ready,
        input  gnt, dp_a, dp_b, dp_c, rsp_valid, rsp_id, rsp_x, busy
    );
endinterface

// File: rtl/comb_eval_arbiter.sv
// Round-robin arbiter/sequencer sharing one (a ^ b) | c datapath among N
// requesters: grant, drive registered operands, capture result, respond.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : comb_eval_arbiter_if.slave (requests, datapath, response)
module comb_eval_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    comb_eval_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gnt_nxt;
    logic            r_dp_a;
    logic            r_dp_b;
    logic            r_dp_c;
    logic            w_dp_a_nxt;
    logic            w_dp_b_nxt;
    logic            w_dp_c_nxt;
    logic            r_rsp_valid;
    logic            w_rsp_valid_nxt;
    logic [ID_W-1:0] r_rsp_id;
    logic [ID_W-1:0] w_rsp_id_nxt;
    logic            r_rsp_x;
    logic            w_rsp_x_nxt;
    logic [ID_W-1:0] r_last_id;
    logic [ID_W-1:0] w_last_id_nxt;

    logic [ID_W-1:0] w_cand;
    logic [ID_W-1:0] w_win;
    logic            w_found;

    // Round-robin pick: first requester at or after last_id+1, wrapping at N
    always_comb begin
        w_cand  = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = ID_W'((32'(r_last_id) + k) % N);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Next-state and next-register values
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_dp_a_nxt      = r_dp_a;
        w_dp_b_nxt      = r_dp_b;
        w_dp_c_nxt      = r_dp_c;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_x_nxt     = r_rsp_x;
        w_last_id_nxt   = r_last_id;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_dp_a_nxt    = bus.a_in[w_win];
                    w_dp_b_nxt    = bus.b_in[w_win];
                    w_dp_c_nxt    = bus.c_in[w_win];
                    w_rsp_id_nxt  = w_win;
                    w_last_id_nxt = w_win;
                    w_gnt_nxt     = N'(1) << w_win;
                    w_state_nxt   = S_EVAL;
                end
            end
            S_EVAL: begin
                // Datapath has had a full cycle to settle on the dp_* registers
                w_rsp_x_nxt     = bus.dp_x;
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_dp_a      <= 1'b0;
            r_dp_b      <= 1'b0;
            r_dp_c      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_x     <= 1'b0;
            r_last_id   <= ID_W'(N - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_dp_a      <= w_dp_a_nxt;
            r_dp_b      <= w_dp_b_nxt;
            r_dp_c      <= w_dp_c_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_x     <= w_rsp_x_nxt;
            r_last_id   <= w_last_id_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.dp_a      = r_dp_a;
    assign bus.dp_b      = r_dp_b;
    assign bus.dp_c      = r_dp_c;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_x     = r_rsp_x;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_comb_eval_arbiter.sv
// Self-checking bench for comb_eval_arbiter: table of single transactions,
// plus hand-written round-robin, backpressure, reset and wrap sequences.
// Responses are checked against a scoreboard queue filled at stimulus time.
module tb_comb_eval_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned ID_W = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    comb_eval_arbiter_if #(.N(N), .ID_W(ID_W)) bus ();

    comb_eval_arbiter #(.N(N), .ID_W(ID_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Shared datapath model
    assign bus.dp_x = (bus.dp_a ^ bus.dp_b) | bus.dp_c;

    typedef struct {
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        int         id;
        logic       x;
    } vec_t;

    typedef struct {
        int   id;
        logic x;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle (negedge to negedge); a response accepted at the
    // coming edge is popped from the scoreboard and compared first.
    task automatic cyc();
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            check("rsp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                check("rsp_x", 32'(bus.rsp_x), 32'(e.x));
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] onehot(input int id);
        logic [3:0] one;
        one = 4'b0001;
        return one << id;
    endfunction

    // Winner operands as given; other requesters get inverted operands so a
    // wrong operand mux shows up in the result.
    function automatic vec_t mk(input logic [3:0] req, input int id,
                                input logic a1, input logic b1, input logic c1,
                                input logic x);
        vec_t v;
        v.req   = req;
        v.a     = {4{~a1}};
        v.b     = {4{~b1}};
        v.c     = {4{~c1}};
        v.a[id] = a1;
        v.b[id] = b1;
        v.c[id] = c1;
        v.id    = id;
        v.x     = x;
        return v;
    endfunction

    // Entered and left at an IDLE-cycle negedge (cycle 0 -> cycle 3)
    task automatic run_txn(input vec_t v);
        logic [3:0] oh;
        oh = onehot(v.id);
        bus.req       = v.req;
        bus.a_in      = v.a;
        bus.b_in      = v.b;
        bus.c_in      = v.c;
        bus.rsp_ready = 1'b1;
        sb.push_back('{v.id, v.x});
        cyc();
        check("txn_gnt", 32'(bus.gnt), 32'(oh));
        check("txn_busy1", 32'(bus.busy), 32'd1);
        check("txn_dp", 32'({bus.dp_a, bus.dp_b, bus.dp_c}),
              32'({v.a[v.id], v.b[v.id], v.c[v.id]}));
        bus.req = v.req & ~oh;
        cyc();
        check("txn_valid", 32'(bus.rsp_valid), 32'd1);
        check("txn_gnt_off", 32'(bus.gnt), 32'd0);
        check("txn_busy2", 32'(bus.busy), 32'd1);
        cyc();
        check("txn_valid_off", 32'(bus.rsp_valid), 32'd0);
        check("txn_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req       = '0;
        cyc();
        cyc();
        reset_n = 1'b1;
        sb.delete();
    endtask

    vec_t       vecs[12];
    logic [7:0] sweep_x;
    logic [2:0] abc;
    logic [3:0] rr_x;
    logic [3:0] exp_gnt;

    initial begin
        bus.req       = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.c_in      = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_dp", 32'({bus.dp_a, bus.dp_b, bus.dp_c}), 32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_id", 32'(bus.rsp_id), 32'd0);
        check("rst_x", 32'(bus.rsp_x), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        cyc();
        reset_n = 1'b1;

        // Transaction table (bit i of sweep_x is (a^b)|c for abc == i)
        sweep_x  = 8'b1011_1110;
        vecs[0]  = mk(4'b0001, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            abc         = 3'(i);
            vecs[1 + i] = mk(4'b0100, 2, abc[2], abc[1], abc[0], sweep_x[i]);
        end
        vecs[9]  = mk(4'b1010, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(4'b1010, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[11] = mk(4'b0101, 2, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i]);
        end

        // All requesting: grants rotate 0,1,2,3,0,1 on cycles 1,4,...,16
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.a_in      = 4'b0101;
        bus.b_in      = 4'b0011;
        bus.c_in      = 4'b0000;
        rr_x          = 4'b0110;
        bus.req       = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            sb.push_back('{k % 4, rr_x[k % 4]});
        end
        for (int t = 1; t <= 18; t++) begin
            cyc();
            exp_gnt = (t % 3 == 1 && t <= 16) ? onehot(((t - 1) / 3) % 4) : 4'b0000;
            check("rr_gnt", 32'(bus.gnt), 32'(exp_gnt));
            if (t == 16) bus.req = '0;
        end
        check("rr_drained", 32'(sb.size()), 32'd0);

        // Backpressure on requester 1, requester 3 arrives meanwhile
        do_reset();
        bus.a_in      = 4'b0010;
        bus.b_in      = 4'b0000;
        bus.c_in      = 4'b0000;
        bus.req       = 4'b0010;
        sb.push_back('{1, 1'b1});
        cyc();
        check("bp_gnt1", 32'(bus.gnt), 32'(onehot(1)));
        bus.req = 4'b1000;
        sb.push_back('{3, 1'b0});
        cyc();
        for (int t = 2; t <= 7; t++) begin
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_id", 32'(bus.rsp_id), 32'd1);
            check("bp_x", 32'(bus.rsp_x), 32'd1);
            check("bp_gnt_quiet", 32'(bus.gnt), 32'd0);
            if (t == 7) bus.rsp_ready = 1'b1;
            cyc();
        end
        check("bp_released", 32'(bus.rsp_valid), 32'd0);
        check("bp_idle_gnt", 32'(bus.gnt), 32'd0);
        cyc();
        check("bp_gnt3", 32'(bus.gnt), 32'(onehot(3)));
        bus.req = '0;
        cyc();
        check("bp_valid3", 32'(bus.rsp_valid), 32'd1);
        cyc();
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Reset while in EVAL discards the transaction
        bus.rsp_ready = 1'b1;
        bus.a_in      = 4'b1000;
        bus.b_in      = 4'b0000;
        bus.c_in      = 4'b0000;
        bus.req       = 4'b1000;
        cyc();
        check("re_gnt", 32'(bus.gnt), 32'(onehot(3)));
        reset_n = 1'b0;
        bus.req = '0;
        cyc();
        reset_n = 1'b1;
        check("re_valid", 32'(bus.rsp_valid), 32'd0);
        check("re_gnt_off", 32'(bus.gnt), 32'd0);
        check("re_dp", 32'({bus.dp_a, bus.dp_b, bus.dp_c}), 32'd0);
        check("re_busy", 32'(bus.busy), 32'd0);
        for (int t = 0; t < 4; t++) begin
            cyc();
            check("re_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run_txn(mk(4'b0110, 1, 1'b1, 1'b0, 1'b1, 1'b1));

        // Grant 3, then 1001 wraps to 0 before 3
        run_txn(mk(4'b1000, 3, 1'b0, 1'b1, 1'b0, 1'b1));
        run_txn(mk(4'b1001, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        run_txn(mk(4'b1000, 3, 1'b1, 1'b1, 1'b1, 1'b1));

        check("final_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
